// File: rtl/list_packer_if.sv
// Word-in / packet-out handshake bundle for list_packer.
interface list_packer_if #(parameter int DW = 32);
    logic [DW-1:0]       IN;
    logic                i_last;
    logic                i_valid;
    logic                o_ready;
    logic [3:0][DW-1:0]  OUT;
    logic                o_valid;
    logic                i_ready;

    modport master (output IN, i_last, i_valid, i_ready, input o_ready, OUT, o_valid);
    modport slave  (input IN, i_last, i_valid, i_ready, output o_ready, OUT, o_valid);
endinterface

// File: rtl/list_packer.sv
// Packs a serial word stream into 4-word packets (toggling header + up to 3 data words).
// Optional idle-flush of partial packets under LIST_PACKER_TIMEOUT_EN.
module list_packer #(
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic         CLK,
    input  logic         RESET,
    list_packer_if.slave bus
);
    typedef enum logic {FILL, FULL} state_t;

    state_t               state, state_nx;
    logic [2:0][DW-1:0]   asm_w;
    logic [2:0][DW-1:0]   words;
    logic [1:0]           cnt;
    logic                 tog;
    logic                 acc, slot, close, load, tmo;
    logic [1:0]           n;
    logic [3:0][DW-1:0]   pkt;

    assign bus.o_ready = (state == FILL);

`ifdef LIST_PACKER_TIMEOUT_EN
    logic [15:0] tmr;

    // Close on the idle edge that brings the count to TIMEOUT.
    assign tmo = (state == FILL) && (cnt != 2'd0) && !acc && (tmr == 16'(TIMEOUT - 1));

    always_ff @(posedge CLK) begin
        if (RESET || acc || close)
            tmr <= '0;
        else if (state == FILL && cnt != 2'd0)
            tmr <= tmr + 16'd1;
    end
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        acc      = bus.i_valid && (state == FILL);
        slot     = !bus.o_valid || bus.i_ready;
        close    = (acc && (cnt == 2'd2 || bus.i_last)) || tmo;
        state_nx = state;
        load     = 1'b0;
        n        = cnt;
        // The closing word goes straight into the packet, not via asm_w.
        words    = asm_w;
        if (acc)
            words[cnt] = bus.IN;
        case (state)
            FILL: begin
                if (close) begin
                    n = acc ? 2'(cnt + 2'd1) : cnt;
                    if (slot) load = 1'b1;
                    else      state_nx = FULL;
                end
            end
            FULL: begin
                if (slot) begin
                    load     = 1'b1;
                    state_nx = FILL;
                end
            end
            default: state_nx = FILL;
        endcase
        pkt       = '0;
        pkt[0][2:0] = {n, tog};
        for (int k = 1; k < 4; k++)
            pkt[k] = (k <= int'(n)) ? words[k-1] : '0;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= FILL;
            asm_w       <= '0;
            cnt         <= '0;
            tog         <= 1'b0;
            bus.OUT     <= '0;
            bus.o_valid <= 1'b0;
        end else begin
            state <= state_nx;
            if (acc)
                asm_w <= words;
            if (load) begin
                bus.OUT     <= pkt;
                bus.o_valid <= 1'b1;
                tog         <= ~tog;
                cnt         <= '0;
            end else begin
                if (bus.i_ready)
                    bus.o_valid <= 1'b0;
                // In FULL, cnt holds the data-word count of the parked packet.
                if (close)
                    cnt <= n;
                else if (acc)
                    cnt <= cnt + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_list_packer.sv
// Randomised + directed bench for list_packer against a queue-based packet model.
module tb_list_packer;
    localparam int DW = 32;
    localparam int PW = 4 * DW;
    localparam int TMO = 16;
    typedef logic [3:0][DW-1:0] pkt_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    list_packer_if #(.DW(DW)) bus();
    list_packer #(.DW(DW), .TIMEOUT(TMO)) dut (.CLK(clk), .RESET(rst), .bus(bus));

    always #5 clk = ~clk;

    // Model: packets closed but not yet consumed; front one is what OUT must show.
    pkt_t          q[$];
    logic [DW-1:0] part[$];
    logic          mtog = 1'b0;
    int            idle = 0;

    task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic mclose();
        pkt_t p;
        p = '0;
        p[0] = DW'(part.size() * 2 + int'(mtog));
        for (int k = 0; k < part.size(); k++)
            p[k+1] = part[k];
        q.push_back(p);
        mtog = ~mtog;
        part.delete();
        idle = 0;
    endtask

    initial forever begin
        @(posedge clk);
        if (rst) begin
            q.delete();
            part.delete();
            mtog = 1'b0;
            idle = 0;
        end else begin
            bit rdy, acc;
            rdy = q.size() < 2;
            acc = bus.i_valid && rdy;
            if (q.size() > 0 && bus.i_ready)
                void'(q.pop_front());
            if (acc) begin
                part.push_back(bus.IN);
                idle = 0;
                if (part.size() == 3 || bus.i_last) mclose();
            end
`ifdef LIST_PACKER_TIMEOUT_EN
            else if (part.size() > 0 && rdy) begin
                idle++;
                if (idle == TMO) mclose();
            end
`endif
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("o_valid", PW'(bus.o_valid), PW'(q.size() > 0));
            chk("o_ready", PW'(bus.o_ready), PW'(q.size() < 2));
            if (q.size() > 0) chk("OUT", PW'(bus.OUT), PW'(q[0]));
        end
    end

    function automatic pkt_t mfront();
        return (q.size() > 0) ? q[0] : pkt_t'('0);
    endfunction

    task automatic send(input logic [DW-1:0] w, input logic l);
        bit r;
        int k = 0;
        bus.i_valid = 1'b1;
        bus.IN      = w;
        bus.i_last  = l;
        while (1) begin
            r = bus.o_ready;
            @(posedge clk);
            if (r) break;
            if (++k > 200) begin
                chk("send_timeout", PW'(1), PW'(0));
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.i_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_o_valid", PW'(bus.o_valid), PW'(0));
        chk("rst_OUT", PW'(bus.OUT), PW'(0));
        chk("rst_o_ready", PW'(bus.o_ready), PW'(1));
    endtask

    initial begin
        pkt_t e;
        bus.IN = '0; bus.i_last = 1'b0; bus.i_valid = 1'b0; bus.i_ready = 1'b1;
        do_reset();

        // Back-to-back full packets: headers 6, 7, 6.
        send(32'hA, 0); send(32'hB, 0); send(32'hC, 0);
        e = {32'hC, 32'hB, 32'hA, 32'h6};
        chk("abc_dut", PW'(bus.OUT), PW'(e));
        chk("abc_model", PW'(mfront()), PW'(e));
        chk("abc_valid", PW'(bus.o_valid), PW'(1));
        send(32'hD, 0); send(32'hE, 0); send(32'hF, 0);
        e = {32'hF, 32'hE, 32'hD, 32'h7};
        chk("def_dut", PW'(bus.OUT), PW'(e));
        chk("def_model", PW'(mfront()), PW'(e));
        send(1, 0); send(2, 0); send(3, 0);
        chk("hdr3", PW'(bus.OUT[0]), PW'(6));

        // Short packets closed by i_last.
        do_reset();
        send(32'hA, 0); send(32'hB, 1);
        e = {32'h0, 32'hB, 32'hA, 32'h4};
        chk("ab_last", PW'(bus.OUT), PW'(e));
        chk("ab_model", PW'(mfront()), PW'(e));
        send(32'hC, 1);
        chk("c_last", PW'(bus.OUT), PW'({32'h0, 32'h0, 32'hC, 32'h3}));

        // Backpressure: one packet in OUT, one parked, then release.
        do_reset();
        bus.i_ready = 1'b0;
        fork
            for (int w = 1; w <= 9; w++) send(DW'(w), 0);
        join_none
        repeat (12) @(negedge clk);
        chk("bp_hold", PW'(bus.OUT), PW'({32'd3, 32'd2, 32'd1, 32'h6}));
        chk("bp_ready", PW'(bus.o_ready), PW'(0));
        bus.i_ready = 1'b1;
        @(negedge clk);
        chk("bp_rel", PW'(bus.OUT), PW'({32'd6, 32'd5, 32'd4, 32'h7}));
        wait fork;
        chk("bp_last", PW'(bus.OUT), PW'({32'd9, 32'd8, 32'd7, 32'h6}));
        chk("bp_last_v", PW'(bus.o_valid), PW'(1));

        // Reset mid-packet restarts toggle.
        send(32'h11, 0); send(32'h22, 0);
        do_reset();
        send(32'h33, 0); send(32'h44, 0); send(32'h55, 0);
        chk("post_rst", PW'(bus.OUT), PW'({32'h55, 32'h44, 32'h33, 32'h6}));

        // Random traffic.
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            bus.i_valid = ($urandom_range(0, 3) != 0);
            bus.IN      = $urandom;
            bus.i_last  = ($urandom_range(0, 4) == 0);
            bus.i_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
        bus.i_ready = 1'b1;

        // Idle behaviour with a single partial word.
        do_reset();
        send(32'hBEEF, 0);
`ifdef LIST_PACKER_TIMEOUT_EN
        repeat (TMO - 1) @(negedge clk);
        chk("tmo_early", PW'(bus.o_valid), PW'(0));
        @(negedge clk);
        chk("tmo_fire", PW'(bus.o_valid), PW'(1));
        chk("tmo_pkt", PW'(bus.OUT), PW'({32'h0, 32'h0, 32'hBEEF, 32'h2}));
`else
        repeat (100) @(negedge clk);
        chk("no_tmo", PW'(bus.o_valid), PW'(0));
        send(32'hCAFE, 1);
        chk("late_close", PW'(bus.OUT), PW'({32'h0, 32'hCAFE, 32'hBEEF, 32'h4}));
`endif
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
